// File: rtl/dsp_pkg.sv
// Shared definitions for the read-order scheduling slice.
//   AXI_LEN_W      : AXI4 ARLEN width.
//   clog2_min1     : ceil(log2(n)), but never below 1 (index widths).
//   order_entry_t  : one outstanding read burst {slv_id, len}.
//   ord_state_e    : scheduler FSM states.
package dsp_pkg;

    localparam int AXI_LEN_W = 8;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_SLV_AMT  = 2;
    localparam int DEF_SLV_ID_W = clog2_min1(DEF_SLV_AMT);

    typedef struct packed {
        logic [DEF_SLV_ID_W-1:0] slv_id;
        logic [AXI_LEN_W-1:0]    len;
    } order_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } ord_state_e;

endpackage

// File: rtl/dsp_order_queue.sv
// Circular buffer of outstanding read bursts, in AR acceptance order.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data     : write an entry at the tail
//   pop                 : retire the head entry
//   head                : current head entry
//   head_next           : entry that will be at the head after this cycle's
//                         push/pop (only meaningful if the queue is non-empty then)
//   count, full, empty  : occupancy
module dsp_order_queue
    import dsp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  order_entry_t       push_data,
    input  logic               pop,
    output order_entry_t       head,
    output order_entry_t       head_next,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    order_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             drains;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // When the queue runs dry this cycle, the only candidate for the next
    // head is the entry being written right now (it is not in mem yet).
    always_comb begin
        rd_ptr_nxt = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        drains     = pop ? (count == CNT_W'(1)) : empty;
        head_next  = drains ? push_data : mem[rd_ptr_nxt];
    end

endmodule

// File: rtl/dsp_ar_order_ctrl.sv
// Per-master read-order scheduler. Records the owning slave of every accepted
// AR burst and steers the RDATA dispatcher to the oldest one; retires it on
// the master-side RLAST handshake and checks beat count against ARLEN.
// Ports:
//   ACLK_i, ARESET_i           : clock, synchronous active-high reset
//   ar_valid_i/slv_id_i/len_i  : AR request from the AR dispatcher
//   ar_ready_i / ar_ready_o    : downstream AR ready / gated ready to master
//   m_RVALID_i/RREADY_i/RLAST_i: master-side R channel observation
//   dsp_AR_slv_id_o            : registered slave select to RDATA dispatcher
//   dsp_AR_disable_o           : registered forwarding disable (1 when idle)
//   outst_cnt_o                : queued bursts
//   r_len_err_o                : sticky burst-length error
//   state_dbg_o                : FSM state for observation
// Handshake: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready. AR: ar_valid_i/ar_ready_o. R: RVALID/RREADY
// while forwarding is enabled.
module dsp_ar_order_ctrl
    import dsp_pkg::*;
#(
    parameter int SLV_AMT     = 2,
    parameter int SLV_ID_W    = clog2_min1(SLV_AMT),
    parameter int LEN_W       = AXI_LEN_W,
    parameter int OUTST_DEPTH = 4,
    parameter int CNT_W       = $clog2(OUTST_DEPTH + 1)
) (
    input  logic                ACLK_i,
    input  logic                ARESET_i,
    input  logic                ar_valid_i,
    input  logic [SLV_ID_W-1:0] ar_slv_id_i,
    input  logic [LEN_W-1:0]    ar_len_i,
    input  logic                ar_ready_i,
    output logic                ar_ready_o,
    input  logic                m_RVALID_i,
    input  logic                m_RREADY_i,
    input  logic                m_RLAST_i,
    output logic [SLV_ID_W-1:0] dsp_AR_slv_id_o,
    output logic                dsp_AR_disable_o,
    output logic [CNT_W-1:0]    outst_cnt_o,
    output logic                r_len_err_o,
    output ord_state_e          state_dbg_o
);

    localparam logic [LEN_W:0] BEAT_MAX = {1'b1, {LEN_W{1'b0}}};

    ord_state_e        state_q, state_nxt;
    logic [SLV_ID_W-1:0] slv_id_q;
    logic [LEN_W:0]    beat_cnt;
    logic              len_err_q;

    logic              q_full, q_empty;
    logic [CNT_W-1:0]  q_count;
    order_entry_t      q_wdata, q_head, q_head_next;
    logic              push, rhs, pop, len_bad;
    logic [LEN_W:0]    head_len;

    // No bypass: a full queue refuses the AR even if a burst retires now.
    assign ar_ready_o = ar_ready_i & ~q_full & ~ARESET_i;
    assign push       = ar_valid_i & ar_ready_o;
    assign rhs        = m_RVALID_i & m_RREADY_i & ~dsp_AR_disable_o;
    assign pop        = rhs & m_RLAST_i & ~q_empty;

    always_comb begin
        q_wdata        = '0;
        q_wdata.slv_id = DEF_SLV_ID_W'(ar_slv_id_i);
        q_wdata.len    = AXI_LEN_W'(ar_len_i);
    end

    dsp_order_queue #(
        .DEPTH (OUTST_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk       (ACLK_i),
        .rst       (ARESET_i),
        .push      (push),
        .push_data (q_wdata),
        .pop       (pop),
        .head      (q_head),
        .head_next (q_head_next),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign head_len = {1'b0, LEN_W'(q_head.len)};

    // Wrong length on RLAST, or a beat past ARLEN that is not marked last.
    assign len_bad = (pop & (beat_cnt != head_len)) |
                     (rhs & ~m_RLAST_i & (beat_cnt == head_len));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (push) state_nxt = ST_BURST;
            ST_BURST: if (pop && !push && (q_count == CNT_W'(1))) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            state_q   <= ST_IDLE;
            slv_id_q  <= '0;
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            // Loading from the next head gives back-to-back bursts without a
            // bubble; in IDLE the select keeps its last value.
            if (state_nxt == ST_BURST) slv_id_q <= SLV_ID_W'(q_head_next.slv_id);
            if (pop)
                beat_cnt <= '0;
            else if (rhs && (beat_cnt != BEAT_MAX))
                beat_cnt <= beat_cnt + (LEN_W+1)'(1);
            if (len_bad) len_err_q <= 1'b1;
        end
    end

    assign dsp_AR_slv_id_o  = slv_id_q;
    assign dsp_AR_disable_o = (state_q == ST_IDLE);
    assign outst_cnt_o      = q_count;
    assign r_len_err_o      = len_err_q;
    assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_dsp_ar_order_ctrl.sv
module tb_dsp_ar_order_ctrl;
    import dsp_pkg::*;

    localparam int SLV_ID_W = 1;
    localparam int LEN_W    = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;
    localparam int EW       = SLV_ID_W + LEN_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                ar_valid = 1'b0;
    logic [SLV_ID_W-1:0] ar_slv_id = '0;
    logic [LEN_W-1:0]    ar_len = '0;
    logic                ar_ready_in = 1'b0;
    logic                ar_ready_out;
    logic                rvalid = 1'b0;
    logic                rready = 1'b0;
    logic                rlast = 1'b0;
    logic [SLV_ID_W-1:0] slv_id;
    logic                dis;
    logic [CNT_W-1:0]    outst_cnt;
    logic                len_err;
    ord_state_e          state_dbg;

    dsp_ar_order_ctrl #(
        .SLV_AMT     (2),
        .SLV_ID_W    (SLV_ID_W),
        .LEN_W       (LEN_W),
        .OUTST_DEPTH (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .ACLK_i           (clk),
        .ARESET_i         (rst),
        .ar_valid_i       (ar_valid),
        .ar_slv_id_i      (ar_slv_id),
        .ar_len_i         (ar_len),
        .ar_ready_i       (ar_ready_in),
        .ar_ready_o       (ar_ready_out),
        .m_RVALID_i       (rvalid),
        .m_RREADY_i       (rready),
        .m_RLAST_i        (rlast),
        .dsp_AR_slv_id_o  (slv_id),
        .dsp_AR_disable_o (dis),
        .outst_cnt_o      (outst_cnt),
        .r_len_err_o      (len_err),
        .state_dbg_o      (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp_v);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int   beats  = 0;
    logic mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        logic push_s, rhs_s, pop_s;
        if (rst) begin
            exp_q.delete();
            beats = 0;
        end else if (mon_en) begin
            chk("sb_cnt", int'(outst_cnt), exp_q.size());
            push_s = ar_valid && ar_ready_out;
            rhs_s  = rvalid && rready && !dis;
            pop_s  = rhs_s && rlast;
            if (pop_s) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", exp_q.size(), 1);
                end else begin
                    chk("sb_slv", int'(slv_id), int'(exp_q[0][EW-1 -: SLV_ID_W]));
                    void'(exp_q.pop_front());
                end
                beats = 0;
            end else if (rhs_s) begin
                beats++;
            end
            if (push_s) exp_q.push_back({ar_slv_id, ar_len});
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int rst, av, sid, len, ai, rv, rr, rl;
        int e_ardy, e_dis, e_sid, e_cnt, e_err;
    } vec_t;

    function automatic vec_t mk(input string name, input int rst_v, av, sid, len, ai, rv, rr, rl,
                                input int e_ardy, e_dis, e_sid, e_cnt, e_err);
        vec_t v;
        v.name = name; v.rst = rst_v; v.av = av; v.sid = sid; v.len = len; v.ai = ai;
        v.rv = rv; v.rr = rr; v.rl = rl;
        v.e_ardy = e_ardy; v.e_dis = e_dis; v.e_sid = e_sid; v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    // Drive one cycle's inputs after the edge, check outputs on the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        @(posedge clk);
        #1;
        rst         = v.rst[0];
        ar_valid    = v.av[0];
        ar_slv_id   = SLV_ID_W'(v.sid);
        ar_len      = LEN_W'(v.len);
        ar_ready_in = v.ai[0];
        rvalid      = v.rv[0];
        rready      = v.rr[0];
        rlast       = v.rl[0];
        @(negedge clk);
        tag = $sformatf("%s[%0d]", v.name, idx);
        chk({tag, "_ardy"}, int'(ar_ready_out), v.e_ardy);
        if (v.rst == 0) begin
            chk({tag, "_dis"}, int'(dis), v.e_dis);
            chk({tag, "_sid"}, int'(slv_id), v.e_sid);
            chk({tag, "_cnt"}, int'(outst_cnt), v.e_cnt);
            chk({tag, "_err"}, int'(len_err), v.e_err);
        end
    endtask

    vec_t tbl[$];

    initial begin
        //                name     rst av sid len ai rv rr rl   ardy dis sid cnt err
        tbl.push_back(mk("single", 0, 1, 1, 3, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("single", 0, 0, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("single", 0, 0, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("single", 0, 0, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("single", 0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 1, 0));
        tbl.push_back(mk("single", 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0));
        tbl.push_back(mk("order",  0, 1, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 0));
        tbl.push_back(mk("order",  0, 1, 1, 1, 1, 1, 1, 1,   1, 0, 0, 1, 0));
        tbl.push_back(mk("order",  0, 1, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("order",  0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 2, 0));
        tbl.push_back(mk("order",  0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 0, 1, 0));
        tbl.push_back(mk("order",  0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("full",   0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("full",   0, 1, 0, 0, 1, 0, 0, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("full",   0, 1, 1, 0, 1, 0, 0, 0,   1, 0, 1, 2, 0));
        tbl.push_back(mk("full",   0, 1, 0, 0, 1, 0, 0, 0,   1, 0, 1, 3, 0));
        tbl.push_back(mk("full",   0, 1, 1, 0, 1, 1, 1, 1,   0, 0, 1, 4, 0));
        tbl.push_back(mk("full",   0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 3, 0));
        tbl.push_back(mk("full",   0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 0, 3, 0));
        tbl.push_back(mk("full",   0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 2, 0));
        tbl.push_back(mk("full",   0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 0, 1, 0));
        tbl.push_back(mk("full",   0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("lenerr", 0, 1, 1, 2, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("lenerr", 0, 0, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("lenerr", 0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 1, 0));
        tbl.push_back(mk("lenerr", 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 1));
        tbl.push_back(mk("lenerr", 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 1));
        tbl.push_back(mk("rstmid", 0, 1, 1, 3, 1, 0, 0, 0,   1, 1, 1, 0, 1));
        tbl.push_back(mk("rstmid", 0, 1, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 1));
        tbl.push_back(mk("rstmid", 0, 1, 1, 0, 1, 1, 1, 0,   1, 0, 1, 2, 1));
        tbl.push_back(mk("rstmid", 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 3, 1));
        tbl.push_back(mk("rstmid", 1, 1, 1, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk("rstmid", 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        tbl.push_back(mk("rstmid", 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("early",  0, 1, 1, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk("early",  0, 0, 0, 0, 1, 1, 1, 0,   1, 0, 1, 1, 0));
        tbl.push_back(mk("early",  0, 0, 0, 0, 1, 1, 1, 1,   1, 0, 1, 1, 1));
        tbl.push_back(mk("early",  0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 0, 1));
        tbl.push_back(mk("rand_rst", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Random traffic with well-formed bursts; RLAST placed by the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rst         = 1'b0;
            ar_valid    = 1'($urandom_range(0, 1));
            ar_slv_id   = SLV_ID_W'($urandom_range(0, 1));
            ar_len      = LEN_W'($urandom_range(0, 2));
            ar_ready_in = ($urandom_range(0, 3) != 0);
            rvalid      = 1'($urandom_range(0, 1));
            rready      = ($urandom_range(0, 3) != 0);
            rlast       = (exp_q.size() != 0) ? (beats == int'(exp_q[0][LEN_W-1:0])) : 1'b0;
        end
        // Drain with a bounded budget.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            ar_valid = 1'b0;
            rvalid   = 1'b1;
            rready   = 1'b1;
            rlast    = (exp_q.size() != 0) ? (beats == int'(exp_q[0][LEN_W-1:0])) : 1'b0;
        end
        @(negedge clk);
        chk("drain_cnt", int'(outst_cnt), 0);
        chk("drain_dis", int'(dis), 1);
        chk("rand_err",  int'(len_err), 0);
        chk("drain_model", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_ar_order_ctrl.md
Name: dsp_ar_order_ctrl

Overview:
- Per-master read-order scheduler. It sequences the RDATA dispatcher by recording, in AR-acceptance order, which slave owns each outstanding read burst.
- It presents the head entry as the dispatcher's slave select and disable, and retires the entry on the master-side RLAST handshake.
- It counts beats against ARLEN and flags length mismatches.
- It sits between the AR channel dispatcher and the RDATA channel dispatcher of one master port.

Parameters:
- SLV_AMT, 2, number of slaves the master can address.
- SLV_ID_W, max(1,$clog2(SLV_AMT)), slave index width.
- LEN_W, 8, AXI4 ARLEN width.
- OUTST_DEPTH, 4, maximum outstanding read bursts. Power of two, ≥2.
- CNT_W, $clog2(OUTST_DEPTH+1), outstanding-count width.

Ports:
- ACLK_i in 1: clock. All logic is synchronous to its rising edge.
- ARESET_i in 1: synchronous, active-high reset.
- ar_valid_i in 1: AR request valid from the AR dispatcher.
- ar_slv_id_i in SLV_ID_W: decoded target slave of the AR request.
- ar_len_i in LEN_W: ARLEN of the AR request.
- ar_ready_i in 1: downstream (slave arbitration) AR ready.
- ar_ready_o out 1: gated AR ready returned to the master.
- m_RVALID_i in 1: RVALID as driven to the master by the RDATA dispatcher.
- m_RREADY_i in 1: master RREADY.
- m_RLAST_i in 1: RLAST as driven to the master.
- dsp_AR_slv_id_o out SLV_ID_W: slave select to the RDATA dispatcher.
- dsp_AR_disable_o out 1: forwarding disable to the RDATA dispatcher.
- outst_cnt_o out CNT_W: number of queued bursts.
- r_len_err_o out 1: sticky burst-length error.

Behaviour:
- Definitions:
  - full = (outst_cnt == OUTST_DEPTH); empty = (outst_cnt == 0).
  - push = ar_valid_i & ar_ready_o.
  - rhs = m_RVALID_i & m_RREADY_i & ~dsp_AR_disable_o.
  - pop = rhs & m_RLAST_i.
- ar_ready_o = ar_ready_i & ~full & ~ARESET_i, combinational. While full, push is blocked even if pop occurs in the same cycle (no bypass).
- Queue entries are {slv_id, len}, written at tail on push and read at head. Pointers wrap modulo OUTST_DEPTH.
- outst_cnt update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Entry visibility: a push at cycle t makes the entry visible at the head at t+1, with disable deasserted at t+1 if the queue was empty. There is no same-cycle bypass.
- FSM states:
  - IDLE: queue empty. dsp_AR_disable_o=1 and dsp_AR_slv_id_o holds its last value (0 after reset). Moves to BURST when a push occurs.
  - BURST: head valid. dsp_AR_disable_o=0 and dsp_AR_slv_id_o = head slv_id, both registered.
    - Each rhs increments beat_cnt (LEN_W+1 bits, starting at 0).
    - On pop: if beat_cnt != head len, set r_len_err_o. Then clear beat_cnt and advance the head.
    - Next state is BURST if a further entry remains (counting a same-cycle push), else IDLE.
    - Back-to-back bursts: the next head's select is valid at t+1 with no idle bubble.
- Early-LAST check: an rhs with m_RLAST_i=0 while beat_cnt == head len sets r_len_err_o. The burst keeps forwarding until RLAST.
- Beat-count saturation: beat_cnt saturates at 2^LEN_W and does not wrap.
- r_len_err_o is cleared only by reset.
- Reset values and reset behaviour:
  - Queue pointers=0, outst_cnt=0, beat_cnt=0, state=IDLE, dsp_AR_disable_o=1, dsp_AR_slv_id_o=0, r_len_err_o=0.
  - Reset mid-burst discards all queued entries with no retirement.
  - Inputs are ignored during the reset cycle.
- Width rule: ar_slv_id_i values ≥ SLV_AMT are stored unchanged; range checking belongs to the AR decoder.

Decomposition:
- Shared package dsp_pkg:
  - Constant AXI_LEN_W=8.
  - Function clog2_min1.
  - Entry struct typedef for order_entry_t {slv_id, len}.
  - Localparam enum for FSM states {ST_IDLE, ST_BURST}.
- Sub-module dsp_order_queue: a synchronous, active-high-reset circular buffer providing push/pop, head output, count, full and empty. It holds the storage and pointers.
- Top-level dsp_ar_order_ctrl holds the FSM, beat counter, error logic and AR gating.

Test Plan:
- Single burst: push {slv=1,len=3} with ar_ready_i=1, then 4 rhs with RLAST on the 4th.
  - Required: disable drops at t+1, slv_id=1, outst_cnt 1→0, disable returns to 1 after the pop, r_len_err_o=0.
- Ordering: push slv 0 (len 0), slv 1 (len 1), slv 0 (len 0) back-to-back, then RREADY held 1.
  - Required: slv_id sequence 0,1,1,0 with no disable bubble between bursts.
- Full: OUTST_DEPTH=4, push 4 entries, then hold ar_valid_i=1 with an rhs+RLAST in the same cycle.
  - Required: ar_ready_o=0 that cycle, no 5th push, and ar_ready_o=1 on the next cycle.
- Length error: push len=2, then RLAST on the 2nd beat.
  - Required: r_len_err_o=1 from the next cycle, sticky; the entry is still popped.
- Early-LAST missing: push len=0, then 2 beats with RLAST only on the 2nd.
  - Required: r_len_err_o=1 after the 1st beat, pop on the 2nd beat.
- Reset mid-operation: 3 entries queued, mid-burst, assert ARESET_i for 1 cycle.
  - Required: next cycle outst_cnt=0, disable=1, slv_id=0, r_len_err_o=0, ar_ready_o follows ar_ready_i.
